// File: rtl/wb_csr_pkg.sv
// Shared constants and types for the Wishbone CSR responder.
// Address map, FSM states and STATUS bit positions.
package wb_csr_pkg;

   localparam logic [13:0] ADR_ID       = 14'h0;
   localparam logic [13:0] ADR_CTRL     = 14'h1;
   localparam logic [13:0] ADR_STATUS   = 14'h2;
   localparam logic [13:0] ADR_COUNTER  = 14'h3;
   localparam logic [13:0] ADR_SCRATCH0 = 14'h4;

   localparam int STATUS_W        = 9;
   localparam int STATUS_UNMAPPED = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK
   } state_t;

   function automatic logic [31:0] sel_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/wb_csr_responder_sel_reg.sv
// 32-bit register with byte-lane masked writes.
// Optional increment when not being written (write wins).
module wb_sel_reg
   import wb_csr_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_we,
   input  logic        i_inc,
   input  logic [3:0]  i_sel,
   input  logic [31:0] i_dat,
   output logic [31:0] o_q
);

   logic [31:0] r_q;
   logic [31:0] w_mask;

   assign w_mask = sel_mask(i_sel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_we && (|i_sel)) begin
         r_q <= (r_q & ~w_mask) | (i_dat & w_mask);
      end else if (i_inc) begin
         r_q <= r_q + 32'd1;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/wb_csr_responder.sv
// Wishbone classic CSR responder: ID, CTRL, W1C STATUS,
// free-running COUNTER and scratch words with wait states.
module wb_csr_responder
   import wb_csr_pkg::*;
#(
   parameter int          NUM_SCRATCH = 4,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] ID_VALUE    = 32'h5742_0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_CYC,
   input  logic        wb_STB,
   input  logic        wb_WE,
   input  logic [13:0] wb_ADR,
   input  logic [3:0]  wb_SEL,
   input  logic [31:0] wb_DAT_MOSI,
   output logic [31:0] wb_DAT_MISO,
   output logic        wb_ACK,
   output logic [31:0] ctrl_out,
   input  logic [7:0]  status_set,
   output logic        irq
);

   localparam logic [13:0] ADR_SCR_END =
      ADR_SCRATCH0 + 14'(NUM_SCRATCH);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_wcnt;
   logic [2:0]  w_wcnt_nxt;
   logic        w_req;
   logic        w_commit;

   logic [13:0] r_adr;
   logic        r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_dat;

   logic [STATUS_W-1:0] r_status;
   logic [STATUS_W-1:0] w_clr;
   logic [31:0] r_miso;
   logic        r_ack;
   logic        r_irq;

   assign w_req = wb_CYC & wb_STB;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_commit    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_state_nxt = ST_WAIT;
               w_wcnt_nxt  = 3'(WAIT_STATES);
            end
         end
         ST_WAIT: begin
            if (!w_req) begin
               w_state_nxt = ST_IDLE;
            end else if (r_wcnt != 3'd0) begin
               w_wcnt_nxt = r_wcnt - 3'd1;
            end else begin
               w_commit    = 1'b1;
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_adr <= '0;
         r_we  <= 1'b0;
         r_sel <= '0;
         r_dat <= '0;
      end else if (r_state == ST_IDLE && w_req) begin
         r_adr <= wb_ADR;
         r_we  <= wb_WE;
         r_sel <= wb_SEL;
         r_dat <= wb_DAT_MOSI;
      end
   end

   logic w_hit_id;
   logic w_hit_ctrl;
   logic w_hit_st;
   logic w_hit_cnt;
   logic w_hit_scr;
   logic w_unmapped;
   logic w_wr;
   logic w_rd;

   assign w_hit_id   = (r_adr == ADR_ID);
   assign w_hit_ctrl = (r_adr == ADR_CTRL);
   assign w_hit_st   = (r_adr == ADR_STATUS);
   assign w_hit_cnt  = (r_adr == ADR_COUNTER);
   assign w_hit_scr  = (r_adr >= ADR_SCRATCH0) &&
                       (r_adr <  ADR_SCR_END);
   assign w_unmapped = ~(w_hit_id | w_hit_ctrl | w_hit_st |
                         w_hit_cnt | w_hit_scr);
   assign w_wr = w_commit & r_we;
   assign w_rd = w_commit & ~r_we;

   logic [31:0] w_ctrl;
   logic [31:0] w_cnt;
   logic [31:0] w_scratch [NUM_SCRATCH];
   logic [2:0]  w_scr_idx;

   // modulo-8 offset is exact because the window never exceeds 8 words
   assign w_scr_idx = r_adr[2:0] - ADR_SCRATCH0[2:0];

   wb_sel_reg u_ctrl (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_wr & w_hit_ctrl),
      .i_inc (1'b0),
      .i_sel (r_sel),
      .i_dat (r_dat),
      .o_q   (w_ctrl)
   );

   wb_sel_reg u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_wr & w_hit_cnt),
      .i_inc (w_ctrl[0]),
      .i_sel (r_sel),
      .i_dat (r_dat),
      .o_q   (w_cnt)
   );

   for (genvar g = 0; g < NUM_SCRATCH; g++) begin : g_scr
      wb_sel_reg u_scr (
         .clk   (clk),
         .rst_n (rst_n),
         .i_we  (w_wr & w_hit_scr & (w_scr_idx == 3'(g))),
         .i_inc (1'b0),
         .i_sel (r_sel),
         .i_dat (r_dat),
         .o_q   (w_scratch[g])
      );
   end

   logic [31:0] w_scr_rd;
   logic [31:0] w_rdata;

   always_comb begin
      w_scr_rd = '0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         if (w_scr_idx == 3'(i)) begin
            w_scr_rd = w_scratch[i];
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      unique case (1'b1)
         w_hit_id:   w_rdata = ID_VALUE;
         w_hit_ctrl: w_rdata = w_ctrl;
         w_hit_st:   w_rdata = {23'd0, r_status};
         w_hit_cnt:  w_rdata = w_cnt;
         w_hit_scr:  w_rdata = w_scr_rd;
         default:    w_rdata = '0;
      endcase
   end

   assign w_clr = {STATUS_W{w_wr & w_hit_st}} &
                  r_dat[STATUS_W-1:0] &
                  {r_sel[1], {8{r_sel[0]}}};

   // set sources are OR-ed after the clear so they win a collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_status <= '0;
         r_irq    <= 1'b0;
         r_ack    <= 1'b0;
         r_miso   <= '0;
      end else begin
         r_status[7:0] <= (r_status[7:0] & ~w_clr[7:0]) | status_set;
         r_status[STATUS_UNMAPPED] <=
            (r_status[STATUS_UNMAPPED] & ~w_clr[STATUS_UNMAPPED]) |
            (w_commit & w_unmapped);
         r_irq <= |(r_status[7:0] & w_ctrl[15:8]);
         r_ack <= w_commit;
         if (w_rd) begin
            r_miso <= w_rdata;
         end
      end
   end

   assign wb_DAT_MISO = r_miso;
   assign wb_ACK      = r_ack;
   assign ctrl_out    = w_ctrl;
   assign irq         = r_irq;

endmodule

// File: tb/tb_wb_csr_responder.sv
// Directed bench for wb_csr_responder, run against
// three instances with 1, 0 and 7 wait states.
module tb_wb_csr_responder;
   import wb_csr_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc  [3];
   logic        stb  [3];
   logic        we   [3];
   logic [13:0] adr  [3];
   logic [3:0]  sel  [3];
   logic [31:0] mosi [3];
   logic [31:0] miso [3];
   logic        ack  [3];
   logic [31:0] ctrlo[3];
   logic [7:0]  sset [3];
   logic        irqo [3];

   int tests  = 0;
   int errors = 0;
   int ws;
   logic [31:0] g_rd;
   int          g_lat;
   logic        g_ack2;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 7);
      wb_csr_responder #(
         .NUM_SCRATCH (4),
         .WAIT_STATES (WS),
         .ID_VALUE    (32'h5742_0001)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .wb_CYC      (cyc[g]),
         .wb_STB      (stb[g]),
         .wb_WE       (we[g]),
         .wb_ADR      (adr[g]),
         .wb_SEL      (sel[g]),
         .wb_DAT_MOSI (mosi[g]),
         .wb_DAT_MISO (miso[g]),
         .wb_ACK      (ack[g]),
         .ctrl_out    (ctrlo[g]),
         .status_set  (sset[g]),
         .irq         (irqo[g])
      );
   end

   function automatic int ws_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
   endfunction

   task automatic bus(input int k, input logic w, input logic [13:0] a,
                      input logic [3:0] s, input logic [31:0] d);
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w;
      adr[k] = a; sel[k] = s; mosi[k] = d;
      @(posedge clk);
      g_lat = 0;
      do begin
         @(posedge clk); #1;
         g_lat++;
      end while (!ack[k] && g_lat < 20);
      g_rd = miso[k];
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      @(posedge clk); #1;
      g_ack2 = ack[k];
   endtask

   task automatic wr(input int k, input logic [13:0] a,
                     input logic [3:0] s, input logic [31:0] d);
      bus(k, 1'b1, a, s, d);
   endtask

   task automatic rd(input int k, input logic [13:0] a);
      bus(k, 1'b0, a, 4'hF, 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset(input int k);
      rst_n = 1'b0;
      #3;
      tests++; if (ack[k] !== 1'b0) begin errors++; $display("FAIL ws%0d rst_ack got %b exp 0", ws, ack[k]); end
      tests++; if (miso[k] !== 32'h0) begin errors++; $display("FAIL ws%0d rst_miso got %h exp 0", ws, miso[k]); end
      tests++; if (ctrlo[k] !== 32'h0) begin errors++; $display("FAIL ws%0d rst_ctrl got %h exp 0", ws, ctrlo[k]); end
      tests++; if (irqo[k] !== 1'b0) begin errors++; $display("FAIL ws%0d rst_irq got %b exp 0", ws, irqo[k]); end
      do_reset();
      rd(k, ADR_STATUS);
      tests++; if (g_rd !== 32'h0) begin errors++; $display("FAIL ws%0d rst_status got %h exp 0", ws, g_rd); end
      rd(k, ADR_COUNTER);
      tests++; if (g_rd !== 32'h0) begin errors++; $display("FAIL ws%0d rst_counter got %h exp 0", ws, g_rd); end
      rd(k, ADR_SCRATCH0);
      tests++; if (g_rd !== 32'h0) begin errors++; $display("FAIL ws%0d rst_scratch got %h exp 0", ws, g_rd); end
   endtask

   task automatic test_scratch(input int k);
      wr(k, 14'h4, 4'hF, 32'hDEAD_BEEF);
      tests++; if (g_lat !== ws + 1) begin errors++; $display("FAIL ws%0d wr_latency got %0d exp %0d", ws, g_lat, ws + 1); end
      rd(k, 14'h4);
      tests++; if (g_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws%0d scr_full got %h exp deadbeef", ws, g_rd); end
      tests++; if (g_lat !== ws + 1) begin errors++; $display("FAIL ws%0d rd_latency got %0d exp %0d", ws, g_lat, ws + 1); end
      tests++; if (g_ack2 !== 1'b0) begin errors++; $display("FAIL ws%0d ack_width got %b exp 0", ws, g_ack2); end
      wr(k, 14'h4, 4'b0101, 32'h1122_3344);
      rd(k, 14'h4);
      tests++; if (g_rd !== 32'hDE22_BE44) begin errors++; $display("FAIL ws%0d scr_lanes got %h exp de22be44", ws, g_rd); end
      wr(k, 14'h4, 4'b0000, 32'hFFFF_FFFF);
      rd(k, 14'h4);
      tests++; if (g_rd !== 32'hDE22_BE44) begin errors++; $display("FAIL ws%0d scr_sel0 got %h exp de22be44", ws, g_rd); end
      wr(k, 14'h7, 4'hF, 32'hA5A5_0007);
      rd(k, 14'h7);
      tests++; if (g_rd !== 32'hA5A5_0007) begin errors++; $display("FAIL ws%0d scr_last got %h exp a5a50007", ws, g_rd); end
      rd(k, 14'h4);
      repeat (3) @(posedge clk);
      #1;
      tests++; if (miso[k] !== 32'hDE22_BE44) begin errors++; $display("FAIL ws%0d miso_hold got %h exp de22be44", ws, miso[k]); end
   endtask

   task automatic test_status_irq(input int k);
      sset[k] = 8'h81;
      @(posedge clk); #1 sset[k] = 8'h00;
      wr(k, ADR_CTRL, 4'hF, 32'h0000_0100);
      tests++; if (irqo[k] !== 1'b1) begin errors++; $display("FAIL ws%0d irq_set got %b exp 1", ws, irqo[k]); end
      tests++; if (ctrlo[k] !== 32'h100) begin errors++; $display("FAIL ws%0d ctrl_out got %h exp 100", ws, ctrlo[k]); end
      rd(k, ADR_STATUS);
      tests++; if (g_rd !== 32'h81) begin errors++; $display("FAIL ws%0d status_sticky got %h exp 81", ws, g_rd); end
      wr(k, ADR_STATUS, 4'hF, 32'h1);
      tests++; if (irqo[k] !== 1'b0) begin errors++; $display("FAIL ws%0d irq_clr got %b exp 0", ws, irqo[k]); end
      rd(k, ADR_STATUS);
      tests++; if (g_rd !== 32'h80) begin errors++; $display("FAIL ws%0d w1c got %h exp 80", ws, g_rd); end
      wr(k, ADR_STATUS, 4'b0000, 32'hFF);
      wr(k, ADR_STATUS, 4'b0010, 32'h80);
      rd(k, ADR_STATUS);
      tests++; if (g_rd !== 32'h80) begin errors++; $display("FAIL ws%0d w1c_lanes got %h exp 80", ws, g_rd); end
      sset[k] = 8'h01;
      @(posedge clk); #1 sset[k] = 8'h00;
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1;
      adr[k] = ADR_STATUS; sel[k] = 4'hF; mosi[k] = 32'h1;
      @(posedge clk);
      repeat (ws) @(posedge clk);
      #1 sset[k] = 8'h01;
      @(posedge clk); #1 sset[k] = 8'h00;
      tests++; if (ack[k] !== 1'b1) begin errors++; $display("FAIL ws%0d w1c_race_ack got %b exp 1", ws, ack[k]); end
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      @(posedge clk); #1;
      rd(k, ADR_STATUS);
      tests++; if (g_rd !== 32'h81) begin errors++; $display("FAIL ws%0d set_wins got %h exp 81", ws, g_rd); end
      wr(k, ADR_STATUS, 4'hF, 32'h81);
      wr(k, ADR_CTRL, 4'hF, 32'h0);
      rd(k, ADR_STATUS);
      tests++; if (g_rd !== 32'h0) begin errors++; $display("FAIL ws%0d status_clear got %h exp 0", ws, g_rd); end
   endtask

   task automatic test_counter(input int k);
      logic [31:0] e;
      wr(k, ADR_COUNTER, 4'hF, 32'hFFFF_FFFE);
      rd(k, ADR_COUNTER);
      tests++; if (g_rd !== 32'hFFFF_FFFE) begin errors++; $display("FAIL ws%0d cnt_load got %h exp fffffffe", ws, g_rd); end
      wr(k, ADR_CTRL, 4'hF, 32'h1);
      rd(k, ADR_COUNTER);
      e = 32'hFFFF_FFFE + 32'(ws) + 32'd2;
      tests++; if (g_rd !== e) begin errors++; $display("FAIL ws%0d cnt_run1 got %h exp %h", ws, g_rd, e); end
      rd(k, ADR_COUNTER);
      e = 32'hFFFF_FFFE + 32'(2 * ws) + 32'd5;
      tests++; if (g_rd !== e) begin errors++; $display("FAIL ws%0d cnt_wrap got %h exp %h", ws, g_rd, e); end
      wr(k, ADR_COUNTER, 4'hF, 32'h10);
      rd(k, ADR_COUNTER);
      e = 32'h10 + 32'(ws) + 32'd2;
      tests++; if (g_rd !== e) begin errors++; $display("FAIL ws%0d cnt_wr_wins got %h exp %h", ws, g_rd, e); end
      wr(k, ADR_CTRL, 4'hF, 32'h0);
      wr(k, ADR_ID, 4'hF, 32'h0);
      rd(k, ADR_ID);
      tests++; if (g_rd !== 32'h5742_0001) begin errors++; $display("FAIL ws%0d id_ro got %h exp 57420001", ws, g_rd); end
   endtask

   task automatic test_unmapped(input int k);
      int seen;
      rd(k, 14'h3FFF);
      tests++; if (g_rd !== 32'h0) begin errors++; $display("FAIL ws%0d unmap_data got %h exp 0", ws, g_rd); end
      tests++; if (g_lat !== ws + 1) begin errors++; $display("FAIL ws%0d unmap_lat got %0d exp %0d", ws, g_lat, ws + 1); end
      rd(k, ADR_STATUS);
      tests++; if (g_rd !== 32'h100) begin errors++; $display("FAIL ws%0d unmap_flag got %h exp 100", ws, g_rd); end
      wr(k, ADR_STATUS, 4'hF, 32'h100);
      rd(k, 14'h8);
      tests++; if (g_rd !== 32'h0) begin errors++; $display("FAIL ws%0d scr_end got %h exp 0", ws, g_rd); end
      wr(k, ADR_STATUS, 4'hF, 32'h100);
      rd(k, ADR_STATUS);
      tests++; if (g_rd !== 32'h0) begin errors++; $display("FAIL ws%0d unmap_w1c got %h exp 0", ws, g_rd); end
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1;
      adr[k] = 14'h4; sel[k] = 4'hF; mosi[k] = 32'h0;
      @(posedge clk);
      #1 cyc[k] = 1'b0; stb[k] = 1'b0;
      seen = 0;
      repeat (12) begin @(posedge clk); #1; if (ack[k]) seen++; end
      tests++; if (seen !== 0) begin errors++; $display("FAIL ws%0d abort_wr_ack got %0d exp 0", ws, seen); end
      rd(k, 14'h4);
      tests++; if (g_rd !== 32'hDE22_BE44) begin errors++; $display("FAIL ws%0d abort_wr got %h exp de22be44", ws, g_rd); end
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0;
      adr[k] = 14'h3FFF;
      @(posedge clk);
      #1 stb[k] = 1'b0;
      seen = 0;
      repeat (12) begin @(posedge clk); #1; if (ack[k]) seen++; end
      cyc[k] = 1'b0;
      tests++; if (seen !== 0) begin errors++; $display("FAIL ws%0d abort_rd_ack got %0d exp 0", ws, seen); end
      rd(k, ADR_STATUS);
      tests++; if (g_rd !== 32'h0) begin errors++; $display("FAIL ws%0d abort_flag got %h exp 0", ws, g_rd); end
   endtask

   task automatic test_reset_mid(input int k);
      int seen;
      wr(k, ADR_CTRL, 4'hF, 32'h0000_FF00);
      tests++; if (ctrlo[k] !== 32'hFF00) begin errors++; $display("FAIL ws%0d pre_rst_ctrl got %h exp ff00", ws, ctrlo[k]); end
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1;
      adr[k] = ADR_CTRL; sel[k] = 4'hF; mosi[k] = 32'h1234;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests++; if (ack[k] !== 1'b0) begin errors++; $display("FAIL ws%0d mid_rst_ack got %b exp 0", ws, ack[k]); end
      tests++; if (ctrlo[k] !== 32'h0) begin errors++; $display("FAIL ws%0d mid_rst_ctrl got %h exp 0", ws, ctrlo[k]); end
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      repeat (12) begin @(posedge clk); #1; if (ack[k]) seen++; end
      tests++; if (seen !== 0) begin errors++; $display("FAIL ws%0d post_rst_ack got %0d exp 0", ws, seen); end
      rd(k, ADR_CTRL);
      tests++; if (g_rd !== 32'h0) begin errors++; $display("FAIL ws%0d post_rst_ctrl got %h exp 0", ws, g_rd); end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
         adr[i] = '0; sel[i] = '0; mosi[i] = '0; sset[i] = '0;
      end
      #12;
      for (int k = 0; k < 3; k++) begin
         ws = ws_of(k);
         test_reset(k);
         test_scratch(k);
         test_status_irq(k);
         test_counter(k);
         test_unmapped(k);
         test_reset_mid(k);
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule
